// File: rtl/count_rx_pkg.sv
// Shared types and defaults for the count frame receiver.
// Holds the FSM state encoding used by count_frame_rx.
package count_rx_pkg;

  localparam int COUNT_W_DEF = 16;
  localparam int NCH_DEF     = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_e;

endpackage

// File: rtl/count_frame_rx_sync_edge.sv
// Multi-bit synchronizer for transmitter-side inputs.
// Bit 0 is sclk; its rising edge yields a one-clk tick.
module sync_edge #(
  parameter int W      = 9,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         rise
);

  logic [W-1:0] stg_q [STAGES];
  logic [W-1:0] stg_d [STAGES];
  logic         prev_q;
  logic         prev_d;

  always_comb begin
    stg_d[0] = d;
    for (int i = 1; i < STAGES; i++) begin
      stg_d[i] = stg_q[i-1];
    end
    prev_d = stg_q[STAGES-1][0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) begin
        stg_q[i] <= '0;
      end
      prev_q <= 1'b0;
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        stg_q[i] <= stg_d[i];
      end
      prev_q <= prev_d;
    end
  end

  assign q    = stg_q[STAGES-1];
  assign rise = q[0] & ~prev_q;

endmodule

// File: rtl/count_frame_rx.sv
// Serial count-frame receiver: synchronizes a transmitter
// stream, assembles frames and stores them per channel.
module count_frame_rx
  import count_rx_pkg::*;
#(
  parameter int COUNT_W     = COUNT_W_DEF,
  parameter int NCH         = NCH_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sclk,
  input  logic                   serial_in,
  input  logic                   sl,
  input  logic [3:0]             addr,
  input  logic                   ovf_ch,
  input  logic                   ovf_global,
  input  logic                   clr_ovf,
  input  logic [$clog2(NCH)-1:0] rd_addr,
  output logic [COUNT_W-1:0]     rd_data,
  output logic                   rd_ovf,
  output logic [COUNT_W-1:0]     word,
  output logic [$clog2(NCH)-1:0] word_ch,
  output logic                   word_valid,
  output logic                   frame_err,
  output logic                   addr_err,
  output logic                   ovf_sticky,
  output logic                   busy
);

  localparam int AW = $clog2(NCH);
  localparam int CW = $clog2(COUNT_W + 1);

  logic [8:0] raw_v;
  logic [8:0] syn_v;
  logic       tick;
  logic       s_sin, s_sl, s_ovf_ch, s_ovf_g;
  logic [3:0] s_addr;

  assign raw_v = {ovf_global, ovf_ch, addr, sl, serial_in, sclk};

  sync_edge #(.W(9), .STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (raw_v),
    .q     (syn_v),
    .rise  (tick)
  );

  assign s_sin    = syn_v[1];
  assign s_sl     = syn_v[2];
  assign s_addr   = syn_v[6:3];
  assign s_ovf_ch = syn_v[7];
  assign s_ovf_g  = syn_v[8];

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [COUNT_W-1:0] shreg_q, shreg_d;
  logic [3:0]         alat_q, alat_d;
  logic               olat_q, olat_d;
  logic [COUNT_W-1:0] word_q, word_d;
  logic [AW-1:0]      word_ch_q, word_ch_d;
  logic               wv_q, wv_d;
  logic               fe_q, fe_d;
  logic               ae_q, ae_d;
  logic               sticky_q, sticky_d;
  logic               wr_en;
  logic               addr_ok;
  logic [COUNT_W-1:0] bank_q [NCH];
  logic               bovf_q [NCH];
  logic [COUNT_W-1:0] rd_data_q;
  logic               rd_ovf_q;

  assign addr_ok = 32'(alat_q) < 32'(NCH);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    alat_d    = alat_q;
    olat_d    = olat_q;
    word_d    = word_q;
    word_ch_d = word_ch_q;
    wv_d      = 1'b0;
    fe_d      = 1'b0;
    ae_d      = 1'b0;
    wr_en     = 1'b0;
    unique case (state_q)
      ST_SHIFT: begin
        if (tick && s_sl) begin
          fe_d    = 1'b1;
          alat_d  = s_addr;
          olat_d  = s_ovf_ch;
          cnt_d   = '0;
          shreg_d = '0;
        end else if (tick) begin
          shreg_d = {shreg_q[COUNT_W-2:0], s_sin};
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CW'(COUNT_W - 1)) begin
            state_d = ST_DONE;
            // Outputs and bank land together in the DONE cycle
            if (addr_ok) begin
              wv_d      = 1'b1;
              wr_en     = 1'b1;
              word_d    = shreg_d;
              word_ch_d = alat_q[AW-1:0];
            end else begin
              ae_d = 1'b1;
            end
          end
        end
      end
      default: begin
        if (state_q == ST_DONE) state_d = ST_IDLE;
        if (tick && s_sl) begin
          state_d = ST_SHIFT;
          alat_d  = s_addr;
          olat_d  = s_ovf_ch;
          cnt_d   = '0;
          shreg_d = '0;
        end
      end
    endcase
    sticky_d = sticky_q;
    if (clr_ovf) sticky_d = 1'b0;
    if (tick && s_ovf_g) sticky_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      shreg_q   <= '0;
      alat_q    <= '0;
      olat_q    <= 1'b0;
      word_q    <= '0;
      word_ch_q <= '0;
      wv_q      <= 1'b0;
      fe_q      <= 1'b0;
      ae_q      <= 1'b0;
      sticky_q  <= 1'b0;
      rd_data_q <= '0;
      rd_ovf_q  <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        bank_q[i] <= '0;
        bovf_q[i] <= 1'b0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      alat_q    <= alat_d;
      olat_q    <= olat_d;
      word_q    <= word_d;
      word_ch_q <= word_ch_d;
      wv_q      <= wv_d;
      fe_q      <= fe_d;
      ae_q      <= ae_d;
      sticky_q  <= sticky_d;
      rd_data_q <= bank_q[rd_addr];
      rd_ovf_q  <= bovf_q[rd_addr];
      if (wr_en) begin
        bank_q[alat_q[AW-1:0]] <= shreg_d;
        bovf_q[alat_q[AW-1:0]] <= olat_q;
      end
    end
  end

  assign rd_data    = rd_data_q;
  assign rd_ovf     = rd_ovf_q;
  assign word       = word_q;
  assign word_ch    = word_ch_q;
  assign word_valid = wv_q;
  assign frame_err  = fe_q;
  assign addr_err   = ae_q;
  assign ovf_sticky = sticky_q;
  assign busy       = (state_q == ST_SHIFT);

endmodule
